// File: rtl/clkgate_pkg.sv
// Shared types and constants for the clock-gated register-file arbiter.
// Contents: FSM state encoding, default address/data widths, requester ids,
// and the width of the idle-hold counter.
package clkgate_pkg;

    localparam int unsigned AW_DEF = 4;
    localparam int unsigned DW_DEF = 8;
    localparam int unsigned HOLD_W = 4;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAKE,
        ST_ACTIVE,
        ST_HOLD
    } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   req_i        : eligible requests (bit k = requester k)
//   adv_i        : a grant is actually issued this cycle; the pointer moves
//   gnt_c_o      : combinational one-hot grant
//   ptr_o        : id of the requester granted last (resets to REQ1)
module rr_arb2
    import clkgate_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       adv_i,
    output logic [1:0] gnt_c_o,
    output logic       ptr_o
);

    logic ptr_q;
    logic ptr_d;

    // On a tie, favour the requester that was not granted last.
    always_comb begin
        gnt_c_o = 2'b00;
        if (req_i == 2'b11) begin
            gnt_c_o = (ptr_q == REQ1) ? 2'b01 : 2'b10;
        end else begin
            gnt_c_o = req_i;
        end
    end

    // Bit 1 of the one-hot grant is the granted requester id.
    always_comb begin
        ptr_d = ptr_q;
        if (adv_i && (gnt_c_o != 2'b00)) begin
            ptr_d = gnt_c_o[1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= REQ1;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/clkgate_rf_arb.sv
// Round-robin arbiter and clock-enable sequencer for a clock-gated 16x8
// register file. Wakes the file's clock one cycle ahead of the first access,
// holds it for IDLE_HOLD cycles after the last access, then drops it.
// Ports:
//   clk_i, rst_i                       : clock, synchronous active-high reset
//   reqK_i/weK_i/addrK_i/wdataK_i      : requester K access, held until gntK_o
//   gntK_o                             : one-cycle grant, access issued this cycle
//   rvalidK_o, rdata_o                 : read return, one cycle after a read grant
//   rf_clken_o/rf_wr_en_o/rf_addr_o/rf_data_o : register file control pins
//   rf_q_i                             : registered register file read data
//   busy_o                             : sequencer not idle
module clkgate_rf_arb
    import clkgate_pkg::*;
#(
    parameter int unsigned AW        = AW_DEF,
    parameter int unsigned DW        = DW_DEF,
    parameter int unsigned IDLE_HOLD = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          req0_i,
    input  logic          we0_i,
    input  logic [AW-1:0] addr0_i,
    input  logic [DW-1:0] wdata0_i,
    input  logic          req1_i,
    input  logic          we1_i,
    input  logic [AW-1:0] addr1_i,
    input  logic [DW-1:0] wdata1_i,
    output logic          gnt0_o,
    output logic          gnt1_o,
    output logic          rvalid0_o,
    output logic          rvalid1_o,
    output logic [DW-1:0] rdata_o,
    output logic          rf_clken_o,
    output logic          rf_wr_en_o,
    output logic [AW-1:0] rf_addr_o,
    output logic [DW-1:0] rf_data_o,
    input  logic [DW-1:0] rf_q_i,
    output logic          busy_o
);

    state_e            state_q;
    logic [HOLD_W-1:0] cnt_q;
    logic [1:0]        gnt_q;
    logic [1:0]        rvalid_q;
    logic              wr_en_q;
    logic              clken_q;
    logic [AW-1:0]     addr_q;
    logic [DW-1:0]     data_q;

    logic [1:0]        elig_c;
    logic [1:0]        arb_gnt_c;
    logic [1:0]        issue_c;
    logic              grant_en_c;
    logic              rd_ret_c;
    logic              arb_ptr;

    // A request is ignored in its own grant cycle so a still-held request
    // is not granted twice.
    assign elig_c = {req1_i & ~gnt_q[1], req0_i & ~gnt_q[0]};

    // Grants are issued only when the FSM moves into ACTIVE.
    always_comb begin
        grant_en_c = 1'b0;
        case (state_q)
            ST_WAKE:            grant_en_c = 1'b1;
            ST_ACTIVE, ST_HOLD: grant_en_c = |elig_c;
            default:            grant_en_c = 1'b0;
        endcase
        issue_c = grant_en_c ? arb_gnt_c : 2'b00;
    end

    rr_arb2 u_arb (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req_i   (elig_c),
        .adv_i   (grant_en_c),
        .gnt_c_o (arb_gnt_c),
        .ptr_o   (arb_ptr)
    );

    // During a grant cycle the arbiter pointer holds the granted id, so it
    // doubles as the one-entry return tag for the read in flight.
    assign rd_ret_c = (|gnt_q) & ~wr_en_q;

    // Sequencer FSM, hold counter and registered register-file pins.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            gnt_q    <= '0;
            rvalid_q <= '0;
            wr_en_q  <= 1'b0;
            clken_q  <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
        end else begin
            gnt_q   <= issue_c;
            wr_en_q <= 1'b0;
            if (issue_c[0]) begin
                wr_en_q <= we0_i;
                addr_q  <= addr0_i;
                data_q  <= wdata0_i;
            end else if (issue_c[1]) begin
                wr_en_q <= we1_i;
                addr_q  <= addr1_i;
                data_q  <= wdata1_i;
            end

            rvalid_q <= 2'b00;
            if (rd_ret_c) begin
                rvalid_q <= (arb_ptr == REQ1) ? 2'b10 : 2'b01;
            end

            case (state_q)
                ST_IDLE: begin
                    if (|elig_c) begin
                        state_q <= ST_WAKE;
                        clken_q <= 1'b1;
                    end
                end
                ST_WAKE: begin
                    state_q <= ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    if (!(|elig_c)) begin
                        state_q <= ST_HOLD;
                        cnt_q   <= HOLD_W'(IDLE_HOLD - 1);
                    end
                end
                ST_HOLD: begin
                    if (|elig_c) begin
                        state_q <= ST_ACTIVE;
                    end else if (cnt_q == '0) begin
                        state_q <= ST_IDLE;
                        clken_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - HOLD_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    clken_q <= 1'b0;
                end
            endcase
        end
    end

    assign gnt0_o     = gnt_q[REQ0];
    assign gnt1_o     = gnt_q[REQ1];
    assign rvalid0_o  = rvalid_q[REQ0];
    assign rvalid1_o  = rvalid_q[REQ1];
    assign rf_clken_o = clken_q;
    assign rf_wr_en_o = wr_en_q;
    assign rf_addr_o  = addr_q;
    assign rf_data_o  = data_q;
    // The clock is enabled exactly when the FSM is out of IDLE.
    assign busy_o     = clken_q;
    // Read data is forced to zero outside a return cycle so it is 0 in reset.
    assign rdata_o    = (|rvalid_q) ? rf_q_i : '0;

endmodule
